// File: rtl/valid_array_pkg.sv
// Shared FSM encoding and default sizing for the valid-array flush controller.
package valid_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_CHECK  = 2'd3
  } flush_state_t;

  localparam int DEF_ELEMENT_BITS = 1;
  localparam int DEF_NUMBER_SETS  = 64;
  localparam int DEF_NUMBER_WAYS  = 16;

endpackage

// File: rtl/set_sweep_counter.sv
// Set pointer for the flush sweep: load-zero, increment, last-set flag.
module set_sweep_counter #(
  parameter int NUMBER_SETS   = 64,
  parameter int PTR_WIDTH     = 6
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 i_load_zero,
  input  logic                 i_inc,
  output logic [PTR_WIDTH-1:0] o_ptr,
  output logic                 o_last
);

  logic [PTR_WIDTH-1:0] r_ptr;
  logic                 w_last;

  assign w_last = (r_ptr == PTR_WIDTH'(NUMBER_SETS - 1));

  // Stepping past the last set returns to 0 so odd set counts never overrun.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)
      r_ptr <= '0;
    else if (i_load_zero)
      r_ptr <= '0;
    else if (i_inc)
      r_ptr <= w_last ? '0 : r_ptr + PTR_WIDTH'(1);
  end

  assign o_ptr  = r_ptr;
  assign o_last = w_last;

endmodule

// File: rtl/valid_array_flush_ctrl.sv
// Flush controller for a set/way valid array: clears every set, reads each back,
// and reports the first set that did not read back as all zeros.
module valid_array_flush_ctrl
  import valid_array_pkg::*;
#(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = DEF_ELEMENT_BITS,
  parameter int NUMBER_SETS                 = DEF_NUMBER_SETS,
  parameter int NUMBER_WAYS                 = DEF_NUMBER_WAYS,
  parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
  input  logic                                               clk_in,
  input  logic                                               reset_in,
  input  logic                                               flush_req_in,
  input  logic                                               client_access_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                   client_set_addr_in,
  input  logic                                               client_write_en_in,
  input  logic [NUMBER_WAYS-1:0]                             client_way_select_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]             client_write_element_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS*NUMBER_WAYS-1:0] read_set_valid_in,
  output logic                                               access_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]                   access_set_addr_out,
  output logic                                               write_en_out,
  output logic [NUMBER_WAYS-1:0]                             write_way_select_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]             write_element_out,
  output logic                                               client_stall_out,
  output logic                                               flush_busy_out,
  output logic                                               flush_done_out,
  output logic                                               flush_error_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]                   flush_err_set_out
);

  flush_state_t                     r_state, w_next;
  logic                             w_load_zero, w_inc, w_last, w_accept;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] w_ptr;
  logic                             r_rd_pending;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] r_rd_addr;
  logic                             r_flush_error;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] r_err_set;

  set_sweep_counter #(
    .NUMBER_SETS (NUMBER_SETS),
    .PTR_WIDTH   (SET_PTR_WIDTH_IN_BITS)
  ) u_set_sweep_counter (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .i_load_zero (w_load_zero),
    .i_inc       (w_inc),
    .o_ptr       (w_ptr),
    .o_last      (w_last)
  );

  assign w_accept = (r_state == ST_IDLE) && flush_req_in;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next               = r_state;
    w_load_zero          = 1'b0;
    w_inc                = 1'b0;
    access_en_out        = 1'b0;
    access_set_addr_out  = '0;
    write_en_out         = 1'b0;
    write_way_select_out = '0;
    write_element_out    = '0;
    client_stall_out     = 1'b0;
    flush_busy_out       = 1'b0;
    flush_done_out       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Held at zero during reset so the array sees no stray client access.
        if (!reset_in) begin
          access_en_out        = client_access_en_in;
          access_set_addr_out  = client_set_addr_in;
          write_en_out         = client_write_en_in;
          write_way_select_out = client_way_select_in;
          write_element_out    = client_write_element_in;
        end
        if (flush_req_in) begin
          w_load_zero = 1'b1;
          w_next      = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        access_en_out        = 1'b1;
        access_set_addr_out  = w_ptr;
        write_en_out         = 1'b1;
        write_way_select_out = '1;
        client_stall_out     = 1'b1;
        flush_busy_out       = 1'b1;
        w_inc                = 1'b1;
        if (w_last)
          w_next = ST_VERIFY;
      end
      ST_VERIFY: begin
        access_en_out       = 1'b1;
        access_set_addr_out = w_ptr;
        client_stall_out    = 1'b1;
        flush_busy_out      = 1'b1;
        w_inc               = 1'b1;
        if (w_last)
          w_next = ST_CHECK;
      end
      ST_CHECK: begin
        client_stall_out = 1'b1;
        flush_busy_out   = 1'b1;
        flush_done_out   = 1'b1;
        w_next           = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Read data lags the VERIFY access by one cycle, so remember which set it belongs to.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_rd_pending  <= 1'b0;
      r_rd_addr     <= '0;
      r_flush_error <= 1'b0;
      r_err_set     <= '0;
    end else begin
      r_rd_pending <= (r_state == ST_VERIFY);
      r_rd_addr    <= w_ptr;
      if (w_accept) begin
        r_flush_error <= 1'b0;
        r_err_set     <= '0;
      end else if (r_rd_pending && (|read_set_valid_in) && !r_flush_error) begin
        r_flush_error <= 1'b1;
        r_err_set     <= r_rd_addr;
      end
    end
  end

  assign flush_error_out   = r_flush_error;
  assign flush_err_set_out = r_err_set;

endmodule

// File: tb/tb_valid_array_flush_ctrl.sv
// Directed bench for valid_array_flush_ctrl with a behavioural valid-array model.
module tb_valid_array_flush_ctrl;

  localparam int ELEM = 1;
  localparam int SETS = 64;
  localparam int WAYS = 16;
  localparam int PW   = 6;

  logic            clk_in = 1'b0;
  logic            reset_in;
  logic            flush_req_in;
  logic            client_access_en_in;
  logic [PW-1:0]   client_set_addr_in;
  logic            client_write_en_in;
  logic [WAYS-1:0] client_way_select_in;
  logic [ELEM-1:0] client_write_element_in;
  logic [WAYS-1:0] read_set_valid_in;
  logic            access_en_out;
  logic [PW-1:0]   access_set_addr_out;
  logic            write_en_out;
  logic [WAYS-1:0] write_way_select_out;
  logic [ELEM-1:0] write_element_out;
  logic            client_stall_out;
  logic            flush_busy_out;
  logic            flush_done_out;
  logic            flush_error_out;
  logic [PW-1:0]   flush_err_set_out;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [WAYS-1:0] mem [SETS];
  logic            inject = 1'b0;
  int clr_cnt = 0, rd_cnt = 0, dn_cnt = 0, mon_bad = 0;
  int exp_clr = 0, exp_rd = 0;

  always #5 clk_in = ~clk_in;

  valid_array_flush_ctrl dut (
    .clk_in                  (clk_in),
    .reset_in                (reset_in),
    .flush_req_in            (flush_req_in),
    .client_access_en_in     (client_access_en_in),
    .client_set_addr_in      (client_set_addr_in),
    .client_write_en_in      (client_write_en_in),
    .client_way_select_in    (client_way_select_in),
    .client_write_element_in (client_write_element_in),
    .read_set_valid_in       (read_set_valid_in),
    .access_en_out           (access_en_out),
    .access_set_addr_out     (access_set_addr_out),
    .write_en_out            (write_en_out),
    .write_way_select_out    (write_way_select_out),
    .write_element_out       (write_element_out),
    .client_stall_out        (client_stall_out),
    .flush_busy_out          (flush_busy_out),
    .flush_done_out          (flush_done_out),
    .flush_error_out         (flush_error_out),
    .flush_err_set_out       (flush_err_set_out)
  );

  // Valid array model: masked writes, registered one-cycle read.
  always @(posedge clk_in) begin
    if (access_en_out && write_en_out)
      mem[access_set_addr_out] <= (mem[access_set_addr_out] & ~write_way_select_out) |
                                  (write_element_out[0] ? write_way_select_out : '0);
    if (access_en_out && !write_en_out)
      read_set_valid_in <= (inject && (access_set_addr_out == 6'd9 || access_set_addr_out == 6'd20))
                           ? 16'h0004 : mem[access_set_addr_out];
    else
      read_set_valid_in <= '0;
  end

  always @(negedge clk_in) begin
    if (flush_done_out) dn_cnt = dn_cnt + 1;
    if (flush_busy_out && access_en_out && write_en_out) begin
      if (write_way_select_out !== 16'hFFFF || write_element_out !== 1'b0 ||
          access_set_addr_out !== PW'(exp_clr)) mon_bad = mon_bad + 1;
      exp_clr = exp_clr + 1;
      clr_cnt = clr_cnt + 1;
    end
    if (flush_busy_out && access_en_out && !write_en_out) begin
      if (write_way_select_out !== 16'h0000 || access_set_addr_out !== PW'(exp_rd))
        mon_bad = mon_bad + 1;
      exp_rd = exp_rd + 1;
      rd_cnt = rd_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic client_idle();
    client_access_en_in     = 1'b0;
    client_set_addr_in      = '0;
    client_write_en_in      = 1'b0;
    client_way_select_in    = '0;
    client_write_element_in = '0;
  endtask

  task automatic clear_mon();
    clr_cnt = 0; rd_cnt = 0; exp_clr = 0; exp_rd = 0; mon_bad = 0;
  endtask

  // Called right after the accepting edge; returns the cycle where done is seen.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (flush_done_out !== 1'b1 && cyc < 400) begin
      tick();
      cyc = cyc + 1;
    end
    tests_run++;
    if (flush_done_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_timeout: waited %0d cycles, required done at 129", cyc);
    end
  endtask

  task automatic check_clean_flush(input string name, input int cyc);
    tests_run++;
    if (cyc !== 129) begin tests_failed++; $display("FAIL %s_latency: got %0d, expected 129", name, cyc); end
    tests_run++;
    if (clr_cnt !== 64) begin tests_failed++; $display("FAIL %s_clear_cnt: got %0d, expected 64", name, clr_cnt); end
    tests_run++;
    if (rd_cnt !== 64) begin tests_failed++; $display("FAIL %s_verify_cnt: got %0d, expected 64", name, rd_cnt); end
    tests_run++;
    if (mon_bad !== 0) begin tests_failed++; $display("FAIL %s_sweep_order: got %0d bad accesses, expected 0", name, mon_bad); end
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    flush_req_in = 1'b0;
    client_access_en_in = 1'b1; client_set_addr_in = 6'd12; client_write_en_in = 1'b1;
    client_way_select_in = 16'hA5A5; client_write_element_in = 1'b1;
    tick(); tick();
    tests_run++;
    if ({access_en_out, write_en_out, write_way_select_out, write_element_out, access_set_addr_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_array_ports: got en=%b we=%b way=%h d=%b a=%0d, expected all 0",
               access_en_out, write_en_out, write_way_select_out, write_element_out, access_set_addr_out);
    end
    tests_run++;
    if ({client_stall_out, flush_busy_out, flush_done_out, flush_error_out, flush_err_set_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_status: got stall=%b busy=%b done=%b err=%b set=%0d, expected all 0",
               client_stall_out, flush_busy_out, flush_done_out, flush_error_out, flush_err_set_out);
    end
    client_idle();
    reset_in = 1'b0;
    tick();
  endtask

  task automatic test_client_mirror();
    client_access_en_in = 1'b1; client_set_addr_in = 6'd5; client_write_en_in = 1'b1;
    client_way_select_in = 16'h0008; client_write_element_in = 1'b1;
    #1;
    tests_run++;
    if (access_en_out !== 1'b1 || access_set_addr_out !== 6'd5 || write_en_out !== 1'b1 ||
        write_way_select_out !== 16'h0008 || write_element_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL mirror: got en=%b a=%0d we=%b way=%h d=%b, expected 1 5 1 0008 1",
               access_en_out, access_set_addr_out, write_en_out, write_way_select_out, write_element_out);
    end
    tests_run++;
    if (client_stall_out !== 1'b0 || flush_busy_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL mirror_stall: got stall=%b busy=%b, expected 0 0", client_stall_out, flush_busy_out);
    end
    tick();
    client_idle();
    tests_run++;
    if (mem[5] !== 16'h0008) begin
      tests_failed++;
      $display("FAIL mirror_write: got set5=%h, expected 0008", mem[5]);
    end
  endtask

  task automatic test_flush_clean();
    int cyc;
    int nz;
    for (int s = 0; s < 16; s++) begin
      client_access_en_in = 1'b1; client_write_en_in = 1'b1; client_set_addr_in = PW'(s);
      client_way_select_in = 16'hFFFF; client_write_element_in = 1'b1;
      tick();
    end
    client_idle();
    clear_mon();
    flush_req_in = 1'b1;
    tick();
    flush_req_in = 1'b0;
    wait_done(cyc);
    check_clean_flush("clean", cyc);
    tick();
    tests_run++;
    if (flush_error_out !== 1'b0 || flush_busy_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL clean_status: got err=%b busy=%b, expected 0 0", flush_error_out, flush_busy_out);
    end
    nz = 0;
    for (int s = 0; s < SETS; s++) if (mem[s] !== 16'h0) nz++;
    tests_run++;
    if (nz !== 0) begin tests_failed++; $display("FAIL clean_contents: got %0d nonzero sets, expected 0", nz); end
  endtask

  task automatic test_flush_error();
    int cyc;
    inject = 1'b1;
    clear_mon();
    flush_req_in = 1'b1;
    tick();
    flush_req_in = 1'b0;
    wait_done(cyc);
    tests_run++;
    if (cyc !== 129) begin tests_failed++; $display("FAIL error_latency: got %0d, expected 129", cyc); end
    tick();
    inject = 1'b0;
    repeat (5) tick();
    tests_run++;
    if (flush_error_out !== 1'b1 || flush_err_set_out !== 6'd9) begin
      tests_failed++;
      $display("FAIL error_report: got err=%b set=%0d, expected 1 9", flush_error_out, flush_err_set_out);
    end
  endtask

  task automatic test_req_ignored();
    int dn0;
    clear_mon();
    dn0 = dn_cnt;
    flush_req_in = 1'b1;
    tick();
    tests_run++;
    if (flush_error_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL error_clear_on_accept: got err=%b, expected 0", flush_error_out);
    end
    for (int i = 1; i < 200; i++) begin
      flush_req_in = (i < 3) || (i == 50);
      tick();
    end
    flush_req_in = 1'b0;
    tests_run++;
    if (dn_cnt - dn0 !== 1) begin tests_failed++; $display("FAIL ignored_req_done: got %0d pulses, expected 1", dn_cnt - dn0); end
    tests_run++;
    if (clr_cnt !== 64 || flush_busy_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignored_req_flush: got clears=%0d busy=%b, expected 64 0", clr_cnt, flush_busy_out);
    end
  endtask

  task automatic test_reset_midflush();
    int dn0;
    int cyc;
    flush_req_in = 1'b1;
    tick();
    flush_req_in = 1'b0;
    repeat (29) tick();
    client_access_en_in = 1'b1; client_set_addr_in = 6'd33; client_write_en_in = 1'b1;
    client_way_select_in = 16'h00F0; client_write_element_in = 1'b1;
    dn0 = dn_cnt;
    #2 reset_in = 1'b1;
    #1;
    tests_run++;
    if ({access_en_out, write_en_out, write_way_select_out, write_element_out, access_set_addr_out,
         client_stall_out, flush_busy_out, flush_done_out} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got en=%b we=%b way=%h stall=%b busy=%b done=%b, expected all 0",
               access_en_out, write_en_out, write_way_select_out, client_stall_out, flush_busy_out, flush_done_out);
    end
    repeat (3) tick();
    reset_in = 1'b0;
    client_idle();
    repeat (150) tick();
    tests_run++;
    if (dn_cnt !== dn0) begin tests_failed++; $display("FAIL midreset_done: got %0d pulses, expected 0", dn_cnt - dn0); end
    clear_mon();
    flush_req_in = 1'b1;
    tick();
    flush_req_in = 1'b0;
    wait_done(cyc);
    check_clean_flush("after_reset", cyc);
  endtask

  task automatic test_same_cycle();
    int cyc;
    tick();
    clear_mon();
    client_access_en_in = 1'b1; client_set_addr_in = 6'd7; client_write_en_in = 1'b1;
    client_way_select_in = 16'h0002; client_write_element_in = 1'b1;
    flush_req_in = 1'b1;
    #1;
    tests_run++;
    if (access_en_out !== 1'b1 || access_set_addr_out !== 6'd7 || write_way_select_out !== 16'h0002 ||
        write_en_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_cycle_client: got en=%b a=%0d way=%h we=%b, expected 1 7 0002 1",
               access_en_out, access_set_addr_out, write_way_select_out, write_en_out);
    end
    tick();
    flush_req_in = 1'b0;
    tests_run++;
    if (mem[7] !== 16'h0002) begin tests_failed++; $display("FAIL same_cycle_write: got set7=%h, expected 0002", mem[7]); end
    tests_run++;
    if (access_set_addr_out !== 6'd0 || write_way_select_out !== 16'hFFFF || write_en_out !== 1'b1 ||
        write_element_out !== 1'b0 || client_stall_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_cycle_clear0: got a=%0d way=%h we=%b d=%b stall=%b, expected 0 FFFF 1 0 1",
               access_set_addr_out, write_way_select_out, write_en_out, write_element_out, client_stall_out);
    end
    client_idle();
    wait_done(cyc);
    check_clean_flush("same_cycle", cyc);
  endtask

  initial begin
    for (int s = 0; s < SETS; s++) mem[s] = '0;
    read_set_valid_in = '0;
    test_reset();
    test_client_mirror();
    test_flush_clean();
    test_flush_error();
    test_req_ignored();
    test_reset_midflush();
    test_same_cycle();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/valid_array_flush_ctrl.md
VALID_ARRAY_FLUSH_CTRL -- requirements
Module: valid_array_flush_ctrl

Interface
REQ-001 Parameter SINGLE_ELEMENT_SIZE_IN_BITS, default 1: bits per valid element.
REQ-002 Parameter NUMBER_SETS, default 64: sets in the downstream valid array.
REQ-003 Parameter NUMBER_WAYS, default 16: ways per set.
REQ-004 Parameter SET_PTR_WIDTH_IN_BITS, default $clog2(NUMBER_SETS): set address width.
REQ-005 clk_in  input  1  sole clock, all state on rising edge.
REQ-006 reset_in  input  1  asynchronous, active-high reset.
REQ-007 flush_req_in  input  1  request to invalidate every set and every way.
REQ-008 client_access_en_in  input  1  client access enable, passed to the array when idle.
REQ-009 client_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  client set address.
REQ-010 client_write_en_in  input  1  client write enable.
REQ-011 client_way_select_in  input  NUMBER_WAYS  client one-hot or multi-hot way select.
REQ-012 client_write_element_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  client write data.
REQ-013 read_set_valid_in  input  SINGLE_ELEMENT_SIZE_IN_BITS*NUMBER_WAYS  array read data, valid one cycle after a read access.
REQ-014 access_en_out, access_set_addr_out, write_en_out, write_way_select_out, write_element_out  outputs  widths as client inputs  drive the valid array ports of the same names without the _out suffix.
REQ-015 client_stall_out  output  1  client accesses are blocked.
REQ-016 flush_busy_out  output  1  flush in progress.
REQ-017 flush_done_out  output  1  one-cycle pulse at flush completion.
REQ-018 flush_error_out  output  1  verify pass found a nonzero set.
REQ-019 flush_err_set_out  output  SET_PTR_WIDTH_IN_BITS  first failing set address.

Function
REQ-020 The FSM SHALL have states IDLE, CLEAR, VERIFY and CHECK.
REQ-021 IDLE: array outputs SHALL combinationally mirror client inputs; client_stall_out=0; flush_busy_out=0.
REQ-022 IDLE with flush_req_in=1: the same-cycle client access SHALL still complete, the set pointer SHALL load 0, flush_error_out and flush_err_set_out SHALL clear, and the FSM SHALL enter CLEAR.
REQ-023 CLEAR: each cycle drive access_en_out=1, write_en_out=1, write_way_select_out=all ones, write_element_out=0, access_set_addr_out=pointer, then increment the pointer; after set NUMBER_SETS-1, load 0 and enter VERIFY.
REQ-024 VERIFY: each cycle drive access_en_out=1, write_en_out=0, write_way_select_out=0, access_set_addr_out=pointer, then increment; after set NUMBER_SETS-1, enter CHECK.
REQ-025 The read_set_valid_in sample of the prior VERIFY cycle SHALL be checked in every VERIFY cycle after the first and in CHECK; any nonzero sample SHALL set flush_error_out.
REQ-026 flush_err_set_out SHALL capture the address of the first failing set only; later failures SHALL not overwrite it.
REQ-027 CHECK: access_en_out=0; flush_done_out=1 for exactly this cycle; next state IDLE.
REQ-028 Latency: flush_done_out SHALL assert 2*NUMBER_SETS+1 cycles after the accepting edge (129 at defaults).
REQ-029 flush_busy_out and client_stall_out SHALL be 1 in CLEAR, VERIFY and CHECK; client inputs SHALL be ignored, not queued.
REQ-030 flush_req_in while not in IDLE SHALL be ignored and not queued.
REQ-031 The pointer SHALL not wrap beyond NUMBER_SETS-1 for non-power-of-two NUMBER_SETS.
REQ-032 flush_error_out and flush_err_set_out SHALL hold until the next accepted flush or reset.

Reset
REQ-033 While reset_in=1: state IDLE, pointer 0, flush_busy_out=0, flush_done_out=0, flush_error_out=0, flush_err_set_out=0, client_stall_out=0, all array outputs 0 regardless of client inputs.
REQ-034 Reset asserted mid-flush SHALL abort immediately with no done pulse; array contents are then unspecified.

Structure
REQ-035 The FSM state encoding and default parameter constants SHALL live in shared package valid_array_pkg.
REQ-036 The set pointer SHALL be sub-module set_sweep_counter (load-zero, increment, last-set flag); everything else SHALL be in the top module.

Verification
REQ-037 Client write set 5 way 3 data 1 while IDLE -> array ports mirror it the same cycle; client_stall_out=0.
REQ-038 Preload sets 0..15 via client, pulse flush_req_in -> 64 CLEAR writes with way select 16'hFFFF and data 0, 64 VERIFY reads, done at cycle 129, flush_error_out=0.
REQ-039 Bench model forces read_set_valid_in=16'h0004 for set 9 and set 20 -> flush_error_out=1, flush_err_set_out=9, done at cycle 129.
REQ-040 flush_req_in held for 3 cycles and pulsed again at cycle 50 -> exactly one flush and one done pulse.
REQ-041 Reset asserted at cycle 30 of a flush -> all outputs 0 asynchronously, no done pulse; new flush after release completes normally.
REQ-042 Client access and flush_req_in in the same IDLE cycle -> client access appears on the array that cycle; CLEAR of set 0 on the next cycle.
